imem_loader: RTL and testbench

Boot-time writer for the instruction memory read by the single-cycle and pipelined cores. It accepts a framed little-endian byte stream over a valid/ready handshake: a 16-bit word count, the payload, and an 8-bit checksum. It assembles 32-bit instructions, writes them to consecutive word addresses from 0, and holds the core stalled until the image is loaded and verified.

---
 rtl/loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// The state enum is exported so the core's top level can monitor loader status.
package loader_pkg;

    localparam int LEN_W = 16;
    localparam int CHK_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words.
// The completed word is presented combinationally alongside its 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_idx;
    logic [23:0] r_lanes;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx   <= 2'd0;
            r_lanes <= 24'd0;
        end else if (i_clear) begin
            r_idx   <= 2'd0;
            r_lanes <= 24'd0;
        end else if (i_byte_en) begin
            case (r_idx)
                2'd0:    r_lanes[7:0]   <= i_byte;
                2'd1:    r_lanes[15:8]  <= i_byte;
                2'd2:    r_lanes[23:16] <= i_byte;
                default: ;
            endcase
            r_idx <= r_idx + 2'd1;
        end
    end

    // The top lane is never stored; it rides straight through with the 4th byte.
    assign o_word      = {i_byte, r_lanes};
    assign o_word_done = i_byte_en && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a length/payload/checksum byte
// stream, writes words from address 0 and holds the core until verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int WIDX_W = $clog2(DEPTH_WORDS + 1);

    state_e             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [WIDX_W-1:0]  r_word_idx;
    logic [CHK_W-1:0]   r_sum;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_hold;
    logic               r_done;
    logic               r_error;

    logic               w_ready;
    logic               w_xfer;
    logic               w_start;
    logic               w_word_en;
    logic               w_word_done;
    logic               w_last_word;
    logic [31:0]        w_word;
    logic [LEN_W-1:0]   w_len_full;
    logic [31:0]        w_addr_next;

    assign w_ready = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                     (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_xfer  = byte_valid && w_ready;
    assign w_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                               (r_state == ST_ERR));

    assign w_word_en   = w_xfer && (r_state == ST_DATA);
    assign w_len_full  = {byte_data, r_len[7:0]};
    assign w_last_word = ({{(LEN_W - WIDX_W){1'b0}}, r_word_idx} + LEN_W'(1)) == r_len;
    assign w_addr_next = 32'({r_word_idx, 2'b00});

    byte_packer u_packer (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (w_start),
        .i_byte_en   (w_word_en),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_sum      <= '0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_state    <= ST_LEN_LO;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_sum      <= '0;
                r_word_idx <= '0;
                r_hold     <= 1'b1;
            end else begin
                case (r_state)
                    ST_LEN_LO: if (w_xfer) begin
                        r_len[7:0] <= byte_data;
                        r_state    <= ST_LEN_HI;
                    end
                    ST_LEN_HI: if (w_xfer) begin
                        r_len[LEN_W-1:8] <= byte_data;
                        if (w_len_full > LEN_W'(DEPTH_WORDS)) begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end else if (w_len_full == '0) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: if (w_xfer) begin
                        r_sum <= r_sum + byte_data;
                        if (w_word_done) begin
                            r_we       <= 1'b1;
                            r_wdata    <= w_word;
                            r_addr     <= w_addr_next;
                            r_word_idx <= r_word_idx + 1'b1;
                            if (w_last_word) r_state <= ST_CHECK;
                        end
                    end
                    // The sum already includes the final payload byte when CHECK is entered.
                    ST_CHECK: if (w_xfer) begin
                        if (byte_data == r_sum) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready = w_ready;
    assign im_we      = r_we;
    assign im_addr    = r_addr;
    assign im_wdata   = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, length limits,
// backpressure and mid-load reset, with writes captured by a monitor.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks;
    int failures;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    imem_loader #(.DEPTH_WORDS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the negedge after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            failures++;
            $display("[TB] FAIL send_byte_timeout: byte_ready=%b, required 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic load_two_word(input logic [7:0] chk);
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                   8'h93, 8'h05, 8'h10, 8'h00};
        stream.push_back(chk);
    endtask

    task automatic send_stream(input bit gaps, input int start_at);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            if (gaps && i != stream.size() - 1) begin
                if (i == start_at) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, im_we, cpu_hold, done, error} !== 5'b00100 ||
            im_addr !== 32'd0 || im_wdata !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: rdy/we/hold/done/err=%b addr=%h wdata=%h, required 00100 0 0",
                     {byte_ready, im_we, cpu_hold, done, error}, im_addr, im_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_outputs: byte_ready=%b cpu_hold=%b, required 0 1", byte_ready, cpu_hold);
        end
    endtask

    task automatic test_two_word();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        load_two_word(8'hC0);
        send_stream(1'b0, -1);
        checks++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL two_word_status: done/hold/err=%b, required 100", {done, cpu_hold, error});
        end
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("[TB] FAIL two_word_count: writes=%0d, required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h00000513) begin
                failures++;
                $display("[TB] FAIL two_word_w0: addr=%h data=%h, required 0 00000513", wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 32'd4 || wr_data[1] !== 32'h00100593) begin
                failures++;
                $display("[TB] FAIL two_word_w1: addr=%h data=%h, required 4 00100593", wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (byte_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_ready: byte_ready=%b, required 0", byte_ready);
        end
    endtask

    task automatic test_bad_checksum();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        checks++;
        if ({done, cpu_hold} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL restart_clears: done/hold=%b, required 01", {done, cpu_hold});
        end
        load_two_word(8'hC1);
        send_stream(1'b0, -1);
        checks++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL bad_chk_status: done/hold/err=%b, required 011", {done, cpu_hold, error});
        end
        checks++;
        if (wr_addr.size() != 2 || wr_data[0] !== 32'h00000513 || wr_data[1] !== 32'h00100593) begin
            failures++;
            $display("[TB] FAIL bad_chk_writes: count=%0d, required 2 writes 00000513 00100593", wr_addr.size());
        end
    endtask

    task automatic test_empty();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        checks++;
        if (done !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL empty_pre: done=%b ready=%b, required 0 1", done, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if ({done, cpu_hold, error} !== 3'b100 || wr_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL empty_result: done/hold/err=%b writes=%0d, required 100 0",
                     {done, cpu_hold, error}, wr_addr.size());
        end
    endtask

    task automatic test_oversize();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        checks++;
        if ({error, done, byte_ready, cpu_hold} !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL oversize_status: err/done/rdy/hold=%b, required 1001",
                     {error, done, byte_ready, cpu_hold});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL oversize_writes: writes=%0d, required 0", wr_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        load_two_word(8'hC0);
        send_stream(1'b1, 4);
        checks++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bp_status: done/hold/err=%b, required 100", {done, cpu_hold, error});
        end
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h00000513 ||
            wr_addr[1] !== 32'd4 || wr_data[1] !== 32'h00100593) begin
            failures++;
            $display("[TB] FAIL bp_writes: count=%0d, required 2 writes 0:00000513 4:00100593", wr_addr.size());
        end
    endtask

    task automatic test_reset_midload();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({byte_ready, im_we, cpu_hold, done, error} !== 5'b00100 ||
            im_addr !== 32'd0 || im_wdata !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midload_reset: rdy/we/hold/done/err=%b addr=%h wdata=%h, required 00100 0 0",
                     {byte_ready, im_we, cpu_hold, done, error}, im_addr, im_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL midload_nowrite: writes=%0d, required 0", wr_addr.size());
        end
        pulse_start();
        load_two_word(8'hC0);
        send_stream(1'b0, -1);
        checks++;
        if (done !== 1'b1 || wr_addr.size() != 2 || wr_data[0] !== 32'h00000513 ||
            wr_data[1] !== 32'h00100593 || wr_addr[1] !== 32'd4) begin
            failures++;
            $display("[TB] FAIL midload_reload: done=%b writes=%0d, required 1 2", done, wr_addr.size());
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rst_n      = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_empty();
        test_oversize();
        test_back_to_back();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
